// File: rtl/bus_pkg.sv
// Shared types and constants for the cpu_core bus responder.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        ACCESS,
        HOLD
    } bus_state_t;

    // Bit of the IRQ control register that holds the pending flag.
    localparam int unsigned IRQ_PEND_BIT = 0;

endpackage

// File: rtl/bus_responder_ram.sv
// Single-port 16-bit RAM: synchronous write, combinational read, no reset.
module bus_responder_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Write port: store the word at the addressed index on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/bus_responder.sv
// Target end of the cpu_core multiplexed bus: address latch, RAM window and
// IRQ register decode, programmable wait states and read-data gating.
module bus_responder
    import bus_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE   = 16'h0000,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] IRQ_ADDR    = 16'hFFFE
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] AdIn,
    output logic [15:0] Data_out,
    input  logic        ALE,
    input  logic        nME,
    input  logic        nOE,
    input  logic        RnW,
    output logic        nWait,
    output logic        nIRQ,
    input  logic        IrqSrc
);

    localparam int unsigned IW = $clog2(DEPTH);

    bus_state_t    state, state_next;
    logic [15:0]   addr, addr_next;
    logic [3:0]    cnt, cnt_next;
    logic [15:0]   rdata, rdata_next;
    logic          pending, pending_next;
    logic          nwait_q, nwait_next;

    logic          ram_hit, irq_hit, hit;
    logic [IW-1:0] ram_idx;
    logic [15:0]   ram_rdata;
    logic          ram_we, irq_we;
    logic [15:0]   read_value;

    // Window check done in 32 bits so ADDR_BASE+DEPTH cannot wrap.
    assign ram_hit = ({16'h0000, addr} >= {16'h0000, ADDR_BASE}) &&
                     ({16'h0000, addr} <  ({16'h0000, ADDR_BASE} + DEPTH));
    assign irq_hit = (addr == IRQ_ADDR);
    assign hit     = ram_hit || irq_hit;
    assign ram_idx = IW'(addr - ADDR_BASE);

    bus_responder_ram #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_ram (
        .clk   (Clock),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (AdIn),
        .rdata (ram_rdata)
    );

    // Select the word returned by a read: IRQ register or RAM.
    always_comb begin
        read_value = '0;
        if (irq_hit) begin
            read_value[IRQ_PEND_BIT] = pending;
        end else begin
            read_value = ram_rdata;
        end
    end

    // Next-state and datapath decisions for one bus access.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        cnt_next   = cnt;
        rdata_next = rdata;
        nwait_next = nwait_q;
        ram_we     = 1'b0;
        irq_we     = 1'b0;

        case (state)
            IDLE: begin
                if (ALE) begin
                    addr_next  = AdIn;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (ALE) begin
                    addr_next = AdIn;
                end else if (!nME) begin
                    if (!hit) begin
                        state_next = HOLD;
                    end else if (WAIT_STATES != 0) begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_STATES - 1);
                        nwait_next = 1'b0;
                    end else begin
                        state_next = ACCESS;
                        if (RnW) rdata_next = read_value;
                    end
                end
            end
            WAIT: begin
                if (nME) begin
                    state_next = IDLE;
                    nwait_next = 1'b1;
                    rdata_next = '0;
                end else if (cnt == 4'd0) begin
                    state_next = ACCESS;
                    nwait_next = 1'b1;
                    if (RnW) rdata_next = read_value;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ACCESS: begin
                if (nME) begin
                    state_next = IDLE;
                    nwait_next = 1'b1;
                    rdata_next = '0;
                end else begin
                    if (!RnW) begin
                        if (irq_hit) irq_we = 1'b1;
                        else         ram_we = 1'b1;
                    end
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (nME) begin
                    state_next = IDLE;
                    nwait_next = 1'b1;
                    rdata_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                nwait_next = 1'b1;
                rdata_next = '0;
            end
        endcase
    end

    // IRQ pending flag: an external pulse overrides a same-cycle clear write.
    always_comb begin
        pending_next = pending;
        if (IrqSrc) begin
            pending_next = 1'b1;
        end else if (irq_we) begin
            pending_next = AdIn[IRQ_PEND_BIT];
        end
    end

    // State register and registered datapath.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            addr    <= '0;
            cnt     <= '0;
            rdata   <= '0;
            pending <= 1'b0;
            nwait_q <= 1'b1;
        end else begin
            state   <= state_next;
            addr    <= addr_next;
            cnt     <= cnt_next;
            rdata   <= rdata_next;
            pending <= pending_next;
            nwait_q <= nwait_next;
        end
    end

    assign Data_out = (!nOE && RnW) ? rdata : '0;
    assign nWait    = nwait_q;
    assign nIRQ     = ~pending;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: one instance with 2 wait states and one
// with none, driven from the same bus signals.
module tb_bus_responder;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] AdIn;
    logic        ALE, nME, nOE, RnW, IrqSrc;

    logic [15:0] data2, data0;
    logic        nwait2, nwait0, nirq2, nirq0;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle samples while nME is low, plus the cycle after nME rises.
    logic [15:0] d2 [8];
    logic [15:0] d0 [8];
    logic        nw2 [8];
    logic        nw0 [8];
    logic        ni2 [8];
    logic        ni0 [8];
    logic        post_nw2, post_ni2, post_ni0;
    logic [15:0] post_d2;

    always #5 Clock = ~Clock;

    bus_responder #(
        .ADDR_BASE   (16'h0000),
        .DEPTH       (256),
        .WAIT_STATES (2),
        .IRQ_ADDR    (16'hFFFE)
    ) u_dut_ws2 (
        .Clock    (Clock),
        .Reset    (Reset),
        .AdIn     (AdIn),
        .Data_out (data2),
        .ALE      (ALE),
        .nME      (nME),
        .nOE      (nOE),
        .RnW      (RnW),
        .nWait    (nwait2),
        .nIRQ     (nirq2),
        .IrqSrc   (IrqSrc)
    );

    bus_responder #(
        .ADDR_BASE   (16'h0000),
        .DEPTH       (256),
        .WAIT_STATES (0),
        .IRQ_ADDR    (16'hFFFE)
    ) u_dut_ws0 (
        .Clock    (Clock),
        .Reset    (Reset),
        .AdIn     (AdIn),
        .Data_out (data0),
        .ALE      (ALE),
        .nME      (nME),
        .nOE      (nOE),
        .RnW      (RnW),
        .nWait    (nwait0),
        .nIRQ     (nirq0),
        .IrqSrc   (IrqSrc)
    );

    // Advance one clock; inputs change and outputs are sampled at the negedge.
    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // One full bus access: ALE cycle, n cycles with nME low, then nME high.
    // IrqSrc is pulsed for the edge with index irq_edge (-1 for none).
    task automatic bus_access(input logic [15:0] a, input logic [15:0] wd,
                              input logic rnw, input int n, input int irq_edge);
        ALE = 1'b1; AdIn = a; nME = 1'b1; nOE = 1'b1; RnW = 1'b1;
        cyc();
        ALE  = 1'b0;
        AdIn = rnw ? 16'h0000 : wd;
        RnW  = rnw;
        nOE  = ~rnw;
        nME  = 1'b0;
        for (int i = 0; i < n; i++) begin
            IrqSrc = (i == irq_edge);
            cyc();
            d2[i] = data2; d0[i] = data0;
            nw2[i] = nwait2; nw0[i] = nwait0;
            ni2[i] = nirq2; ni0[i] = nirq0;
        end
        IrqSrc = 1'b0;
        nME = 1'b1;
        cyc();
        post_nw2 = nwait2; post_d2 = data2;
        post_ni2 = nirq2; post_ni0 = nirq0;
        nOE = 1'b1; RnW = 1'b1; AdIn = 16'h0000;
    endtask

    task automatic test_reset();
        Reset = 1'b1; ALE = 1'b0; nME = 1'b1; nOE = 1'b0; RnW = 1'b1;
        IrqSrc = 1'b0; AdIn = 16'h0000;
        cyc(); cyc();
        if (data2 !== 16'h0000) begin
            $display("FAIL reset_data: got %h expected 0000", data2); n_fail++;
        end
        n_checks++;
        if (nwait2 !== 1'b1 || nwait0 !== 1'b1) begin
            $display("FAIL reset_nwait: got %b/%b expected 1/1", nwait2, nwait0); n_fail++;
        end
        n_checks++;
        if (nirq2 !== 1'b1 || nirq0 !== 1'b1) begin
            $display("FAIL reset_nirq: got %b/%b expected 1/1", nirq2, nirq0); n_fail++;
        end
        n_checks++;
        Reset = 1'b0; nOE = 1'b1;
        cyc();
    endtask

    task automatic test_write_read();
        int lows;
        bus_access(16'h0010, 16'hBEEF, 1'b0, 5, -1);
        lows = 0;
        for (int i = 0; i < 5; i++) if (nw2[i] === 1'b0) lows++;
        if (lows != 2) begin
            $display("FAIL ws2_write_nwait_count: got %0d expected 2", lows); n_fail++;
        end
        n_checks++;
        if (nw2[0] !== 1'b0 || nw2[1] !== 1'b0 || nw2[2] !== 1'b1) begin
            $display("FAIL ws2_write_nwait_shape: got %b%b%b expected 001", nw2[0], nw2[1], nw2[2]); n_fail++;
        end
        n_checks++;
        bus_access(16'h0010, 16'h0000, 1'b1, 5, -1);
        if (d2[1] !== 16'h0000) begin
            $display("FAIL ws2_read_early: got %h expected 0000", d2[1]); n_fail++;
        end
        n_checks++;
        if (d2[2] !== 16'hBEEF) begin
            $display("FAIL ws2_read_access: got %h expected beef", d2[2]); n_fail++;
        end
        n_checks++;
        if (d2[4] !== 16'hBEEF) begin
            $display("FAIL ws2_read_hold: got %h expected beef", d2[4]); n_fail++;
        end
        n_checks++;
        if (post_d2 !== 16'h0000) begin
            $display("FAIL ws2_read_after_nme: got %h expected 0000", post_d2); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_zero_wait();
        int lows;
        bus_access(16'h00FF, 16'h1234, 1'b0, 4, -1);
        bus_access(16'h00FF, 16'h0000, 1'b1, 4, -1);
        lows = 0;
        for (int i = 0; i < 4; i++) if (nw0[i] !== 1'b1) lows++;
        if (lows != 0) begin
            $display("FAIL ws0_nwait: got %0d low cycles expected 0", lows); n_fail++;
        end
        n_checks++;
        if (d0[0] !== 16'h1234) begin
            $display("FAIL ws0_read_first_cycle: got %h expected 1234", d0[0]); n_fail++;
        end
        n_checks++;
        if (d2[2] !== 16'h1234) begin
            $display("FAIL ws2_read_top_word: got %h expected 1234", d2[2]); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_miss();
        int bad;
        bus_access(16'h0400, 16'h0000, 1'b1, 4, -1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (nw2[i] !== 1'b1 || nw0[i] !== 1'b1) bad++;
            if (d2[i] !== 16'h0000 || d0[i] !== 16'h0000) bad++;
        end
        if (bad != 0) begin
            $display("FAIL miss_quiet: got %0d bad samples expected 0", bad); n_fail++;
        end
        n_checks++;
        bus_access(16'h0010, 16'h0000, 1'b1, 4, -1);
        if (d2[2] !== 16'hBEEF || d0[0] !== 16'hBEEF) begin
            $display("FAIL hit_after_miss: got %h/%h expected beef/beef", d2[2], d0[0]); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_irq();
        IrqSrc = 1'b1;
        cyc();
        IrqSrc = 1'b0;
        if (nirq2 !== 1'b0 || nirq0 !== 1'b0) begin
            $display("FAIL irq_pulse: got %b/%b expected 0/0", nirq2, nirq0); n_fail++;
        end
        n_checks++;
        bus_access(16'hFFFE, 16'h0000, 1'b1, 4, -1);
        if (d2[2] !== 16'h0001 || d0[0] !== 16'h0001) begin
            $display("FAIL irq_read: got %h/%h expected 0001/0001", d2[2], d0[0]); n_fail++;
        end
        n_checks++;
        bus_access(16'hFFFE, 16'h0000, 1'b0, 4, -1);
        if (ni2[2] !== 1'b0 || ni2[3] !== 1'b1) begin
            $display("FAIL irq_clear_ws2: got %b%b expected 01", ni2[2], ni2[3]); n_fail++;
        end
        n_checks++;
        if (ni0[0] !== 1'b0 || ni0[1] !== 1'b1) begin
            $display("FAIL irq_clear_ws0: got %b%b expected 01", ni0[0], ni0[1]); n_fail++;
        end
        n_checks++;
        // IrqSrc lands on the ws0 write edge; ws2 writes two edges later.
        bus_access(16'hFFFE, 16'h0000, 1'b0, 4, 1);
        if (ni0[0] !== 1'b1 || ni0[1] !== 1'b0 || post_ni0 !== 1'b0) begin
            $display("FAIL irq_set_wins: got %b%b%b expected 100", ni0[0], ni0[1], post_ni0); n_fail++;
        end
        n_checks++;
        if (ni2[1] !== 1'b0 || post_ni2 !== 1'b1) begin
            $display("FAIL irq_set_then_clear: got %b%b expected 01", ni2[1], post_ni2); n_fail++;
        end
        n_checks++;
        bus_access(16'hFFFE, 16'h0001, 1'b0, 4, -1);
        if (post_ni2 !== 1'b0) begin
            $display("FAIL irq_write_set: got %b expected 0", post_ni2); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_abort();
        bus_access(16'h0020, 16'h5555, 1'b0, 5, -1);
        bus_access(16'h0020, 16'hAAAA, 1'b0, 1, -1);
        if (nw2[0] !== 1'b0) begin
            $display("FAIL abort_in_wait: got %b expected 0", nw2[0]); n_fail++;
        end
        n_checks++;
        if (post_nw2 !== 1'b1) begin
            $display("FAIL abort_nwait: got %b expected 1", post_nw2); n_fail++;
        end
        n_checks++;
        bus_access(16'h0020, 16'h0000, 1'b1, 4, -1);
        if (d2[2] !== 16'h5555) begin
            $display("FAIL abort_mem_ws2: got %h expected 5555", d2[2]); n_fail++;
        end
        n_checks++;
        if (d0[0] !== 16'h5555) begin
            $display("FAIL abort_mem_ws0: got %h expected 5555", d0[0]); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_access();
        // pending is set from the previous test, so nIRQ is low going in.
        ALE = 1'b1; AdIn = 16'h0010; nME = 1'b1;
        cyc();
        ALE = 1'b0; RnW = 1'b1; nOE = 1'b0; nME = 1'b0;
        cyc();
        if (nwait2 !== 1'b0 || data0 !== 16'hBEEF || nirq2 !== 1'b0) begin
            $display("FAIL pre_reset_state: got %b/%h/%b expected 0/beef/0", nwait2, data0, nirq2); n_fail++;
        end
        n_checks++;
        Reset = 1'b1;
        #1;
        if (data0 !== 16'h0000 || data2 !== 16'h0000) begin
            $display("FAIL midreset_data: got %h/%h expected 0000/0000", data2, data0); n_fail++;
        end
        n_checks++;
        if (nwait2 !== 1'b1 || nirq2 !== 1'b1 || nirq0 !== 1'b1) begin
            $display("FAIL midreset_ctrl: got %b/%b/%b expected 1/1/1", nwait2, nirq2, nirq0); n_fail++;
        end
        n_checks++;
        cyc();
        Reset = 1'b0;
        cyc(); cyc();
        if (nwait2 !== 1'b1 || data0 !== 16'h0000) begin
            $display("FAIL idle_after_reset: got %b/%h expected 1/0000", nwait2, data0); n_fail++;
        end
        n_checks++;
        nME = 1'b1; nOE = 1'b1;
        cyc();
        bus_access(16'h0010, 16'h0000, 1'b1, 4, -1);
        if (d2[2] !== 16'hBEEF || nw2[0] !== 1'b0) begin
            $display("FAIL access_after_reset: got %h/%b expected beef/0", d2[2], nw2[0]); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_miss();
        test_irq();
        test_abort();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
